// File: rtl/acq_pkg.sv
// acq_pkg: shared constants for the acquisition Avalon-MM responder.
// Register addresses, CTRL/STATUS bit positions, capture FSM states and
// the LEVEL width helper. Optional feature macro: ACQ_TIMESTAMP_EN.
package acq_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_DATA   = 3'd2;
  localparam logic [2:0] ADDR_THRESH = 3'd3;
  localparam logic [2:0] ADDR_TSTAMP = 3'd4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_LEVEL_W  = 11;
  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_OVERFLOW = 18;
  localparam int STAT_RUN      = 19;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} acq_state_e;

  // LEVEL counter width: one extra bit so DEPTH itself is representable
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acq_fifo.sv
// acq_fifo: synchronous show-ahead FIFO. Head entry is always visible on
// rdata; pop advances the read pointer at the edge. Clear beats push/pop.
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module acq_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // pointer and level bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // storage array, left unreset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acq_avmm_slave.sv
// acq_avmm_slave: Avalon-MM responder buffering a valid-qualified sample
// stream for HPS software. Holds the register file, capture FSM, threshold
// interrupt and 1-cycle-latency readdata mux around an acq_fifo.
// Optional feature macro: ACQ_TIMESTAMP_EN (per-sample 32-bit cycle stamp).
module acq_avmm_slave
  import acq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              irq
);

  localparam int LW = level_w(DEPTH);
`ifdef ACQ_TIMESTAMP_EN
  localparam int FW = DATA_W + 32;
`else
  localparam int FW = DATA_W;
`endif

  acq_state_e  state;
  logic        enable, irq_en, overflow;
  logic [10:0] thresh;
  logic        wr_ctrl, clr, en_next, push_req, pop_req, pop_ok;
  logic [FW-1:0] f_wdata, f_rdata;
  logic [LW-1:0] level;
  logic          full, empty;
  logic [31:0]   status, rd_mux, tstamp;
  logic          unused_ok;

  assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
  assign clr      = wr_ctrl && avs_writedata[CTRL_CLEAR];
  // ENABLE written this cycle already steers the FSM at this edge, so the
  // very next sample is captured
  assign en_next  = wr_ctrl ? avs_writedata[CTRL_ENABLE] : enable;
  assign push_req = (state == ST_RUN) && smp_valid;
  assign pop_req  = avs_read && (avs_address == ADDR_DATA);
  assign pop_ok   = pop_req && !empty && !clr;

  assign unused_ok = ^{avs_writedata[31:19], avs_writedata[17:11]};

`ifdef ACQ_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  assign f_wdata = {cyc_cnt, smp_data};

  // free-running cycle counter, untouched by CLEAR; stamp follows each pop
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cyc_cnt <= '0;
      tstamp  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (pop_ok) tstamp <= f_rdata[FW-1 -: 32];
    end
  end
`else
  assign f_wdata = smp_data;
  assign tstamp  = '0;
`endif

  acq_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .clr   (clr),
    .push  (push_req && !clr),
    .pop   (pop_req && !clr),
    .wdata (f_wdata),
    .rdata (f_rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign status = {12'b0, state == ST_RUN, overflow, full, empty, 5'b0, STAT_LEVEL_W'(level)};

  // control and threshold registers; CLEAR is a pulse and is not stored
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_CTRL: begin
          enable <= avs_writedata[CTRL_ENABLE];
          irq_en <= avs_writedata[CTRL_IRQ_EN];
        end
        ADDR_THRESH: thresh <= avs_writedata[10:0];
        default: ;
      endcase
    end
  end

  // capture FSM: CLEAR forces IDLE for one edge even if ENABLE stays set
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  state <= ST_IDLE;
    else if (clr)        state <= ST_IDLE;
    else if (en_next)    state <= ST_RUN;
    else                 state <= ST_IDLE;
  end

  // sticky overflow: dropped push sets it, W1C or CLEAR clears it
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) overflow <= 1'b0;
    else if (clr)       overflow <= 1'b0;
    else if (push_req && full && !pop_ok) overflow <= 1'b1;
    else if (avs_write && avs_address == ADDR_STATUS && avs_writedata[STAT_OVERFLOW])
      overflow <= 1'b0;
  end

  // readdata source selection for the current read
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:   rd_mux = {29'b0, irq_en, 1'b0, enable};
      ADDR_STATUS: rd_mux = status;
      ADDR_DATA:   rd_mux = empty ? 32'd0 : 32'(f_rdata[DATA_W-1:0]);
      ADDR_THRESH: rd_mux = {21'b0, thresh};
      ADDR_TSTAMP: rd_mux = tstamp;
      default:     rd_mux = '0;
    endcase
  end

  // one-cycle read response; async reset kills any pending valid
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  // level interrupt from the registered (already updated) fill level
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq <= 1'b0;
    else irq <= irq_en && (thresh != '0) && (STAT_LEVEL_W'(level) >= thresh);
  end

endmodule
